// File: rtl/scan_window_sequencer.sv
// Scan-position generator: walks every pyramid level in raster order emitting window origins.
// Level tables default to `PYRAMID_WIDTHS/`PYRAMID_HEIGHTS; `SCAN_PERF_CNT_EN adds perf counters.
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd43, 32'd53, 32'd67, 32'd83, 32'd104, 32'd131, 32'd163, 32'd204, 32'd256, 32'd320}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd32, 32'd40, 32'd50, 32'd62, 32'd78, 32'd98, 32'd122, 32'd153, 32'd192, 32'd240}
`endif

module scan_window_sequencer #(
    parameter int NUM_LEVELS  = 10,
    parameter int WINDOW_SIZE = 24,
    parameter int STEP        = 1,
    parameter int COORD_W     = 16,
    parameter int INT_WAIT    = 10,
    parameter logic [NUM_LEVELS-1:0][31:0] LEVEL_WIDTHS  = `PYRAMID_WIDTHS,
    parameter logic [NUM_LEVELS-1:0][31:0] LEVEL_HEIGHTS = `PYRAMID_HEIGHTS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               win_ready,
    output logic               win_valid,
    output logic [3:0]         win_level,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_last,
    output logic               busy,
    output logic               frame_done
`ifdef SCAN_PERF_CNT_EN
    ,
    output logic [31:0]        perf_windows,
    output logic [31:0]        perf_stalls
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [32:0]        CMAX   = (33'd1 << COORD_W) - 33'd1;
    localparam logic [31:0]        WS32   = 32'(WINDOW_SIZE);
    localparam logic [COORD_W:0]   STEP_W = (COORD_W+1)'(STEP);
    localparam logic [3:0]         LVL_MAX = 4'(NUM_LEVELS - 1);

    logic [15:0]        ok_a;
    logic [COORD_W-1:0] maxr_a [16];
    logic [COORD_W-1:0] maxc_a [16];

    // Per-level last legal origin, computed in 32 bits and truncated.
    for (genvar l = 0; l < 16; l++) begin : g_lvl
        if (l < NUM_LEVELS) begin : g_on
            localparam logic [31:0] LW_P = LEVEL_WIDTHS[l];
            localparam logic [31:0] LH_P = LEVEL_HEIGHTS[l];
            localparam logic [31:0] MC_P = LW_P - WS32 - 32'd1;
            localparam logic [31:0] MR_P = LH_P - WS32 - 32'd1;
            if ({1'b0, LW_P} > CMAX || {1'b0, LH_P} > CMAX) begin : g_err
                $error("level dimension exceeds coordinate width");
            end
            assign ok_a[l]   = (LW_P > WS32) && (LH_P > WS32);
            assign maxc_a[l] = MC_P[COORD_W-1:0];
            assign maxr_a[l] = MR_P[COORD_W-1:0];
        end else begin : g_off
            assign ok_a[l]   = 1'b0;
            assign maxc_a[l] = '0;
            assign maxr_a[l] = '0;
        end
    end

    state_t             state_q, state_d;
    logic [31:0]        wcnt_q, wcnt_d;
    logic [3:0]         level_q, level_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;

    logic               ok_cur;
    logic [COORD_W:0]   col_inc;
    logic [COORD_W:0]   row_inc;
    logic               col_more;
    logic               row_more;
    logic               last_lvl;
    logic               adv;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            level_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            level_q <= level_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        ok_cur   = ok_a[level_q];
        col_inc  = {1'b0, col_q} + STEP_W;
        row_inc  = {1'b0, row_q} + STEP_W;
        col_more = ok_cur && (col_inc <= {1'b0, maxc_a[level_q]});
        row_more = ok_cur && (row_inc <= {1'b0, maxr_a[level_q]});
        // No legal level above this one.
        last_lvl = ok_cur && ((ok_a >> level_q) == 16'd1);
        win_valid  = (state_q == S_SCAN) && ok_cur;
        win_last   = win_valid && last_lvl && !col_more && !row_more;
        busy       = (state_q == S_WAIT) || (state_q == S_SCAN);
        frame_done = (state_q == S_DONE);
        win_level  = level_q;
        win_row    = row_q;
        win_col    = col_q;
        adv        = ok_cur ? win_ready : 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        level_d = level_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    wcnt_d  = 32'd1;
                end
            end
            S_WAIT: begin
                if (wcnt_q >= 32'(INT_WAIT)) begin
                    state_d = S_SCAN;
                    level_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            S_SCAN: begin
                if (adv) begin
                    if (col_more) begin
                        col_d = col_inc[COORD_W-1:0];
                    end else if (row_more) begin
                        col_d = '0;
                        row_d = row_inc[COORD_W-1:0];
                    end else if (level_q == LVL_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        level_d = level_q + 4'd1;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SCAN_PERF_CNT_EN
    logic [31:0] pwin_q;
    logic [31:0] pstall_q;

    always_ff @(posedge clock) begin
        if (reset || (state_q == S_IDLE && start)) begin
            pwin_q   <= '0;
            pstall_q <= '0;
        end else begin
            if (win_valid && win_ready && pwin_q != '1)
                pwin_q <= pwin_q + 32'd1;
            if (win_valid && !win_ready && pstall_q != '1)
                pstall_q <= pstall_q + 32'd1;
        end
    end

    assign perf_windows = pwin_q;
    assign perf_stalls  = pstall_q;
`endif

endmodule

// File: tb/tb_scan_window_sequencer.sv
// Directed bench for scan_window_sequencer: nominal, backpressure, skip,
// stride, busy start and mid-frame reset on a 2-level 5x4/4x3 pyramid.
module tb_scan_window_sequencer;

    typedef struct packed {
        logic [3:0]  l;
        logic [15:0] r;
        logic [15:0] c;
        logic        last;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ready;
    logic [2:0]  st;
    logic [2:0]  v;
    logic [2:0]  lst;
    logic [2:0]  bsy;
    logic [2:0]  dn;
    logic [3:0]  lvl [3];
    logic [15:0] row [3];
    logic [15:0] col [3];
`ifdef SCAN_PERF_CNT_EN
    logic [31:0] pw [3];
    logic [31:0] ps [3];
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    win_t exp_q[$];

    scan_window_sequencer #(
        .NUM_LEVELS(2), .WINDOW_SIZE(2), .STEP(1), .COORD_W(16), .INT_WAIT(3),
        .LEVEL_WIDTHS({32'd4, 32'd5}), .LEVEL_HEIGHTS({32'd3, 32'd4})
    ) u_nom (
        .clock(clk), .reset(rst), .start(st[0]), .win_ready(ready),
        .win_valid(v[0]), .win_level(lvl[0]), .win_row(row[0]), .win_col(col[0]),
        .win_last(lst[0]), .busy(bsy[0]), .frame_done(dn[0])
`ifdef SCAN_PERF_CNT_EN
        , .perf_windows(pw[0]), .perf_stalls(ps[0])
`endif
    );

    scan_window_sequencer #(
        .NUM_LEVELS(2), .WINDOW_SIZE(2), .STEP(1), .COORD_W(16), .INT_WAIT(3),
        .LEVEL_WIDTHS({32'd2, 32'd5}), .LEVEL_HEIGHTS({32'd3, 32'd4})
    ) u_skip (
        .clock(clk), .reset(rst), .start(st[1]), .win_ready(ready),
        .win_valid(v[1]), .win_level(lvl[1]), .win_row(row[1]), .win_col(col[1]),
        .win_last(lst[1]), .busy(bsy[1]), .frame_done(dn[1])
`ifdef SCAN_PERF_CNT_EN
        , .perf_windows(pw[1]), .perf_stalls(ps[1])
`endif
    );

    scan_window_sequencer #(
        .NUM_LEVELS(2), .WINDOW_SIZE(2), .STEP(2), .COORD_W(16), .INT_WAIT(3),
        .LEVEL_WIDTHS({32'd4, 32'd5}), .LEVEL_HEIGHTS({32'd3, 32'd4})
    ) u_str (
        .clock(clk), .reset(rst), .start(st[2]), .win_ready(ready),
        .win_valid(v[2]), .win_level(lvl[2]), .win_row(row[2]), .win_col(col[2]),
        .win_last(lst[2]), .busy(bsy[2]), .frame_done(dn[2])
`ifdef SCAN_PERF_CNT_EN
        , .perf_windows(pw[2]), .perf_stalls(ps[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int l, input int r, input int c, input bit last);
        win_t w;
        w.l = 4'(l);
        w.r = 16'(r);
        w.c = 16'(c);
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic load_nominal();
        exp_q.delete();
        add(0, 0, 0, 0); add(0, 0, 1, 0); add(0, 0, 2, 0);
        add(0, 1, 0, 0); add(0, 1, 1, 0); add(0, 1, 2, 0);
        add(1, 0, 0, 0); add(1, 0, 1, 1);
    endtask

    task automatic chk_win(input string tag, input int k, input win_t w);
        chk({tag, ".valid"}, 32'(v[k]), 32'd1);
        chk({tag, ".level"}, 32'(lvl[k]), 32'(w.l));
        chk({tag, ".row"}, 32'(row[k]), 32'(w.r));
        chk({tag, ".col"}, 32'(col[k]), 32'(w.c));
        chk({tag, ".last"}, 32'(lst[k]), 32'(w.last));
    endtask

    // One frame on instance k; optional stall, busy start, reset or skip tail.
    task automatic run_frame(input string tag, input int k, input int stall_at,
                             input int bstart_at, input int rst_at, input bit skip_tail);
        st[k] = 1'b1;
        tick();
        st = '0;
        tick();
        chk({tag, ".wait1_valid"}, 32'(v[k]), 32'd0);
        chk({tag, ".wait1_busy"}, 32'(bsy[k]), 32'd1);
        tick();
        chk({tag, ".wait2_valid"}, 32'(v[k]), 32'd0);
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            chk_win($sformatf("%s.w%0d", tag, i), k, exp_q[i]);
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                chk({tag, ".rst_valid"}, 32'(v[k]), 32'd0);
                chk({tag, ".rst_busy"}, 32'(bsy[k]), 32'd0);
                chk({tag, ".rst_level"}, 32'(lvl[k]), 32'd0);
                chk({tag, ".rst_row"}, 32'(row[k]), 32'd0);
                chk({tag, ".rst_col"}, 32'(col[k]), 32'd0);
                chk({tag, ".rst_done"}, 32'(dn[k]), 32'd0);
                rst = 1'b0;
                return;
            end
            if (i == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk_win($sformatf("%s.stall%0d", tag, s), k, exp_q[i]);
                end
                ready = 1'b1;
            end
            if (i == bstart_at) st[k] = 1'b1;
            tick();
            st = '0;
        end
        if (skip_tail) begin
            chk({tag, ".skip_valid"}, 32'(v[k]), 32'd0);
            chk({tag, ".skip_busy"}, 32'(bsy[k]), 32'd1);
            chk({tag, ".skip_done"}, 32'(dn[k]), 32'd0);
            tick();
        end
        chk({tag, ".done"}, 32'(dn[k]), 32'd1);
        chk({tag, ".done_valid"}, 32'(v[k]), 32'd0);
        chk({tag, ".done_busy"}, 32'(bsy[k]), 32'd0);
        tick();
        chk({tag, ".done_pulse"}, 32'(dn[k]), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        st    = '0;
        tick();
        tick();
        chk("reset.valid", 32'(v), 32'd0);
        chk("reset.busy", 32'(bsy), 32'd0);
        chk("reset.done", 32'(dn), 32'd0);
        chk("reset.last", 32'(lst), 32'd0);
        chk("reset.level", 32'(lvl[0]), 32'd0);
        chk("reset.row", 32'(row[0]), 32'd0);
        chk("reset.col", 32'(col[0]), 32'd0);
        rst = 1'b0;
        tick();

        load_nominal();
        run_frame("nominal", 0, -1, -1, -1, 1'b0);

        run_frame("bp", 0, 4, -1, -1, 1'b0);
`ifdef SCAN_PERF_CNT_EN
        chk("bp.perf_stalls", ps[0], 32'd5);
        chk("bp.perf_windows", pw[0], 32'd8);
`endif

        exp_q.delete();
        add(0, 0, 0, 0); add(0, 0, 1, 0); add(0, 0, 2, 0);
        add(0, 1, 0, 0); add(0, 1, 1, 0); add(0, 1, 2, 1);
        run_frame("skip", 1, -1, -1, -1, 1'b1);

        exp_q.delete();
        add(0, 0, 0, 0); add(0, 0, 2, 0); add(1, 0, 0, 1);
        run_frame("stride", 2, -1, -1, -1, 1'b0);

        load_nominal();
        run_frame("busystart", 0, -1, 2, -1, 1'b0);

        run_frame("midrst", 0, -1, -1, 3, 1'b0);
        tick();
        run_frame("replay", 0, -1, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
